// File: rtl/axis_mover_pkg.sv
// -----------------------------------------------------------------------------
// axis_mover_pkg
// Shared definitions for the sequenced AXI-Stream mover:
//   mover_state_e : controller state encoding (IDLE, ISSUE, WAIT_RESP, EMIT)
//   clog2_min1()  : ceil(log2(n)) clamped to at least 1, so that counters
//                   sized from a parameter of 0 or 1 still have a legal width
// -----------------------------------------------------------------------------
package axis_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_EMIT      = 2'd3
    } mover_state_e;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/mover_timeout_counter.sv
// -----------------------------------------------------------------------------
// mover_timeout_counter
// Counts cycles while enabled and flags expiry once the count reaches
// TIMEOUT_CYCLES. The count saturates at the limit; TIMEOUT_CYCLES = 0
// disables expiry entirely.
// Ports:
//   clock      - clock
//   reset      - asynchronous active-low reset
//   clear_i    - synchronous clear, has priority over enable_i
//   enable_i   - count this cycle
//   expired_o  - count has reached the limit in an enabled cycle
// -----------------------------------------------------------------------------
module mover_timeout_counter
    import axis_mover_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count equals the number of full wait cycles already elapsed, so the
    // cycle that sees count == LIMIT is the last one in which a response is
    // still accepted.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/axis_sequenced_mover.sv
// -----------------------------------------------------------------------------
// axis_sequenced_mover
// Sweeps CHANNEL_NUMBER channels: for each channel it issues the channel's
// source address on the request stream, waits for one read response, and
// forwards that word with the channel's target address as dest. A response
// that does not arrive within TIMEOUT_CYCLES sets a sticky error and the
// channel is skipped. CONTINUOUS = 1 restarts the sweep after the last channel.
// Ports:
//   clock, reset                      - clock, asynchronous active-low reset
//   start_i                           - begin a sweep (sampled only in IDLE)
//   data_request_{data,valid}_o,
//   data_request_ready_i              - read request stream (source address)
//   data_response_{data,valid}_i,
//   data_response_ready_o             - read response stream
//   data_out_{data,dest,valid}_o,
//   data_out_ready_i                  - moved word with target address
//   busy_o, done_o, timeout_error_o   - status (done is a one-cycle pulse)
// -----------------------------------------------------------------------------
module axis_sequenced_mover
    import axis_mover_pkg::*;
#(
    parameter int                                 DATA_WIDTH     = 32,
    parameter int                                 ADDRESS_WIDTH  = 32,
    parameter int                                 CHANNEL_NUMBER = 4,
    parameter logic [CHANNEL_NUMBER*ADDRESS_WIDTH-1:0] SOURCE_ADDR = '0,
    parameter logic [CHANNEL_NUMBER*ADDRESS_WIDTH-1:0] TARGET_ADDR = '0,
    parameter int                                 TIMEOUT_CYCLES = 64,
    parameter bit                                 CONTINUOUS     = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    output logic [ADDRESS_WIDTH-1:0] data_request_data_o,
    output logic                     data_request_valid_o,
    input  logic                     data_request_ready_i,
    input  logic [DATA_WIDTH-1:0]    data_response_data_i,
    input  logic                     data_response_valid_i,
    output logic                     data_response_ready_o,
    output logic [DATA_WIDTH-1:0]    data_out_data_o,
    output logic [ADDRESS_WIDTH-1:0] data_out_dest_o,
    output logic                     data_out_valid_o,
    input  logic                     data_out_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_error_o
);

    localparam int              CH_W    = clog2_min1(CHANNEL_NUMBER);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL_NUMBER - 1);

    mover_state_e              state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [ADDRESS_WIDTH-1:0]  dest_q, dest_d;
    logic                      done_q, done_d;
    logic                      terr_q, terr_d;
    logic                      advance;
    logic                      expired;
    logic [ADDRESS_WIDTH-1:0]  src_addr;
    logic [ADDRESS_WIDTH-1:0]  tgt_addr;

    assign src_addr = SOURCE_ADDR[int'(ch_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign tgt_addr = TARGET_ADDR[int'(ch_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    // Held in clear outside WAIT_RESP, so every entry starts from zero.
    mover_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (state_q != ST_WAIT_RESP),
        .enable_i  (state_q == ST_WAIT_RESP),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
        dest_d  = dest_q;
        done_d  = 1'b0;
        terr_d  = terr_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    ch_d    = '0;
                    terr_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (data_request_ready_i) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                // A response wins over an expiry in the same cycle.
                if (data_response_valid_i) begin
                    data_d  = data_response_data_i;
                    dest_d  = tgt_addr;
                    state_d = ST_EMIT;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (data_out_ready_i) begin
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Channel completion, whether by transfer or by timeout skip.
        if (advance) begin
            if (ch_q == LAST_CH) begin
                ch_d    = '0;
                done_d  = 1'b1;
                state_d = CONTINUOUS ? ST_ISSUE : ST_IDLE;
            end else begin
                ch_d    = ch_q + 1'b1;
                state_d = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    // All handshake outputs decode directly from the state register, so an
    // asynchronous reset drops them immediately.
    assign data_request_valid_o  = (state_q == ST_ISSUE);
    assign data_request_data_o   = (state_q == ST_ISSUE) ? src_addr : '0;
    assign data_response_ready_o = (state_q == ST_WAIT_RESP);
    assign data_out_valid_o      = (state_q == ST_EMIT);
    assign data_out_data_o       = data_q;
    assign data_out_dest_o       = dest_q;
    assign busy_o                = (state_q != ST_IDLE);
    assign done_o                = done_q;
    assign timeout_error_o       = terr_q;

endmodule

// File: doc/axis_sequenced_mover.md
AXIS_SEQUENCED_MOVER -- requirements
Module: axis_sequenced_mover

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of request, response and output streams.
REQ-002 Parameter ADDRESS_WIDTH, default 32, SHALL set the width of source and target addresses.
REQ-003 Parameter CHANNEL_NUMBER, default 4, SHALL set the channels per sweep; legal range is 1 or more.
REQ-004 Parameter SOURCE_ADDR, default all zero, SHALL hold one ADDRESS_WIDTH source address per channel.
REQ-005 Parameter TARGET_ADDR, default all zero, SHALL hold one ADDRESS_WIDTH target (dest) address per channel.
REQ-006 Parameter TIMEOUT_CYCLES, default 64, SHALL set the response wait limit; 0 disables the timeout.
REQ-007 Parameter CONTINUOUS, default 0, SHALL restart a sweep automatically after the last channel when set to 1.
REQ-008 Port clock, input, 1, SHALL be the single clock.
REQ-009 Port reset, input, 1, SHALL be the asynchronous active-low reset.
REQ-010 Port start, input, 1, SHALL request one sweep; it is sampled only in IDLE.
REQ-011 Port data_request, axi_stream.master, ADDRESS_WIDTH, SHALL carry the source address read request.
REQ-012 Port data_response, axi_stream.slave, DATA_WIDTH, SHALL carry the read data.
REQ-013 Port data_out, axi_stream.master, DATA_WIDTH with dest ADDRESS_WIDTH, SHALL carry the moved word and its target.
REQ-014 Port busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-015 Port done, output, 1, SHALL give a one-cycle pulse when a sweep completes.
REQ-016 Port timeout_error, output, 1, SHALL be a sticky flag set on any response timeout and cleared only by the next accepted start.

Function
REQ-017 The state machine SHALL have four states: IDLE, ISSUE, WAIT_RESP and EMIT.
REQ-018 From IDLE, start=1 SHALL load channel 0, clear timeout_error and go to ISSUE on the next edge.
REQ-019 In ISSUE, data_request.data SHALL be SOURCE_ADDR[ch] with valid=1, held stable until ready=1; the handshake cycle SHALL move to WAIT_RESP.
REQ-020 data_response.ready SHALL be 1 only in WAIT_RESP.
REQ-021 A response handshake (valid and ready) SHALL latch data, set dest to TARGET_ADDR[ch] and move to EMIT.
REQ-022 In EMIT, data_out.valid SHALL stay high with data and dest stable until data_out.ready=1 (backpressure honoured).
REQ-023 After the EMIT handshake, if ch < CHANNEL_NUMBER-1, ch SHALL increment and the state SHALL go to ISSUE.
REQ-024 After the EMIT handshake on the last channel, done SHALL pulse, ch SHALL wrap to 0, and the state SHALL go to ISSUE if CONTINUOUS=1, else IDLE.
REQ-025 In WAIT_RESP, a counter SHALL count cycles; on reaching TIMEOUT_CYCLES without a response, timeout_error SHALL set, no data_out SHALL be emitted, and the channel SHALL advance as in REQ-023/REQ-024.
REQ-026 The timeout counter SHALL be clog2(TIMEOUT_CYCLES+1) bits wide and SHALL clear on every WAIT_RESP entry.
REQ-027 The channel counter SHALL be max(1, clog2(CHANNEL_NUMBER)) bits wide, so CHANNEL_NUMBER=1 is legal.
REQ-028 Minimum latency, start to first data_out.valid, SHALL be 3 cycles with request ready and a zero-wait response.
REQ-029 start asserted outside IDLE SHALL be ignored and not queued.
REQ-030 A response arriving in the same cycle the timeout expires SHALL be accepted, and no error SHALL be flagged.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE with ch=0, all valid and ready outputs 0, data, dest, busy, done and timeout_error 0, and counters 0.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse; after release, operation SHALL resume only on a new start.

Structure
REQ-033 The state enum and a clog2-with-minimum-1 helper function SHALL live in the shared package axis_mover_pkg.
REQ-034 The timeout counter SHALL be the sub-module mover_timeout_counter (inputs clear and enable; output expired).

Verification
REQ-035 CHANNEL_NUMBER=3, ready always 1, one-cycle responses of 0xA, 0xB, 0xC -> data_out carries 0xA/0xB/0xC with dest TARGET_ADDR[0..2], then one done pulse, then IDLE.
REQ-036 data_out.ready held low 5 cycles during EMIT -> valid, data and dest stay stable all 5 cycles; exactly one transfer occurs.
REQ-037 TIMEOUT_CYCLES=8, no response on channel 1 -> timeout_error=1 after 8 cycles, channel 1 skipped, channel 2 still moved, done pulses.
REQ-038 CONTINUOUS=1, CHANNEL_NUMBER=2 -> channel order 0,1,0,1 with done after each sweep, and busy never drops.
REQ-039 reset pulsed low while in WAIT_RESP on channel 2 -> all outputs 0 immediately; the next start begins at channel 0.
REQ-040 start pulsed while busy, and CHANNEL_NUMBER=1 -> no extra sweep occurs; the single channel completes with done.
